// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end that shares one barrel shifter
// between two requesters. Operands are registered onto the shifter
// inputs on accept, the combinational result is captured one cycle
// later and held on a valid/ready response channel tagged with the
// owning requester.
module shift_arbiter #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_b,
    input  logic [1:0]  req0_aluc,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_b,
    input  logic [1:0]  req1_aluc,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_b,
    output logic [1:0]  sh_aluc,
    input  logic [31:0] sh_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PRIO_INIT = (RR_INIT != 0);

    state_t state, state_nx;
    logic   prio;
    logic   owner;
    logic   grant0, grant1;

    // Arbitration and handshake outputs; ready is gated by reset so no
    // request can be accepted while the block is being cleared.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | (prio == 1'b0));
        grant1     = req1_valid & (~req0_valid | (prio == 1'b1));
        req0_ready = (state == IDLE) & grant0 & ~rst;
        req1_ready = (state == IDLE) & grant1 & ~rst;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req0_ready | req1_ready) state_nx = EXEC;
            EXEC: state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand, result and priority registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a     <= '0;
            sh_b     <= '0;
            sh_aluc  <= '0;
            owner    <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            prio     <= PRIO_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        sh_a    <= req0_a;
                        sh_b    <= req0_b;
                        sh_aluc <= req0_aluc;
                        owner   <= 1'b0;
                    end else if (req1_ready) begin
                        sh_a    <= req1_a;
                        sh_b    <= req1_b;
                        sh_aluc <= req1_aluc;
                        owner   <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data <= sh_c;
                    rsp_id   <= owner;
                end
                RESP: begin
                    if (rsp_ready) prio <= ~owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and sequencer that shares one `barrelshifter32` datapath between two requesters. It accepts shift requests over valid/ready handshakes and registers the selected operands onto the shifter's `a`/`b`/`aluc` inputs. It captures the shifter's combinational result `c` one cycle later and returns it on a response channel tagged with the requester id. It sits between the execute-stage requesters and the single shifter instance.

## Interface
- `RR_INIT`, default 0: requester that holds priority after reset (0 or 1).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`  in  32  requester 0 shift source.
- `req0_b`  in  5  requester 0 shift amount.
- `req0_aluc`  in  2  requester 0 op: 00 sra, 01 srl, 10/11 sll.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_aluc`: same as above, for requester 1.
- `sh_a`  out  32  to shifter `a`, registered.
- `sh_b`  out  5  to shifter `b`, registered.
- `sh_aluc`  out  2  to shifter `aluc`, registered.
- `sh_c`  in  32  from shifter `c` (combinational).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_data`  out  32  shift result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE, grant:**
  - One valid requester: that requester is granted.
  - Both valid: the requester holding priority (`prio`) is granted.
  - `reqN_ready` is combinational: `(state==IDLE) & grant_N`. At most one ready is high in any cycle.
- **IDLE, on handshake:**
  - Latch `reqN_a/b/aluc` into `sh_a/sh_b/sh_aluc`.
  - Latch N into `owner`.
  - Go to EXEC.
- **EXEC:**
  - Capture `sh_c` into `rsp_data`, and `owner` into `rsp_id`.
  - Go to RESP.
  - No new request is accepted.
- **RESP:**
  - `rsp_valid` is high.
  - On `rsp_valid & rsp_ready`: go to IDLE and set `prio` to the requester other than `owner`.
  - Otherwise hold. `rsp_data` and `rsp_id` stay stable while `rsp_valid` is high and not accepted.
- `sh_a/sh_b/sh_aluc` hold their last accepted values outside the accept edge. No other logic drives the shifter.
- The block performs no arithmetic. The result is exactly the `sh_c` value sampled in EXEC.
- `prio` changes only on a response handshake. A requester that waits is therefore served next: no starvation.
- `reqN_a/b/aluc` are sampled only in the accept cycle and may change freely otherwise.

## Timing
- **Reset (`rst` high at a clock edge):**
  - `state` goes to IDLE and `prio` to `RR_INIT`.
  - `sh_a`, `sh_b`, `sh_aluc`, `rsp_data`, `rsp_id` and `owner` reset to 0.
  - `rsp_valid` and `busy` go to 0. Both `reqN_ready` outputs are 0 while `rst` is high.
- **Reset mid-operation** (in EXEC or RESP): the operation in flight is dropped and no response is produced.
- **Latency:**
  - Handshake at edge T.
  - Result captured at edge T+1.
  - `rsp_valid` is high in the cycle after T+1.
  - With `rsp_ready` tied high, `rsp_valid` lasts exactly one cycle and `reqN_ready` can go high again in the following cycle.
  - Peak throughput: one operation per 3 cycles.
- **Back-pressure:** while `rsp_ready` is low in RESP, the FSM stays in RESP indefinitely and no `reqN_ready` is asserted.
- **Simultaneous events:**
  - Both requesters are valid and the response is being handshaken in the same cycle: the new grant is not issued that cycle. Arbitration happens in the next IDLE cycle, using the updated `prio`.
  - A request is withdrawn (`valid` drops) before it is granted: no effect.

## Test plan
- **Single op:**
  - Stimulus: `req0` with a=FFFFFFFF, b=4, aluc=11; `rsp_ready`=1.
  - Response: `rsp_valid` goes high 2 cycles after the handshake, with `rsp_data`=FFFFFFF0 and `rsp_id`=0.
- **All ops:**
  - Stimulus: a=80000000 with b=31 under aluc=00, 01 and 10 in turn.
  - Response: `rsp_data`=FFFFFFFF, 00000001 and 00000000 respectively.
- **Contention:**
  - Stimulus: `req0` and `req1` both held valid for 4 operations, `RR_INIT`=0.
  - Response: grant order 0,1,0,1, with `rsp_id` following the same order. `req0_ready` and `req1_ready` are never high in the same cycle.
- **Back-pressure:**
  - Stimulus: hold `rsp_ready`=0 for 5 cycles in RESP.
  - Response: `rsp_valid` stays 1 with `rsp_data` stable; both `reqN_ready` stay 0; `busy`=1. The response is delivered on the first cycle `rsp_ready`=1.
- **Reset mid-op:**
  - Stimulus: assert `rst` in the EXEC cycle.
  - Response: on the next cycle `rsp_valid`=0, `busy`=0, and `sh_a`, `sh_b`, `sh_aluc`, `rsp_data` are all 0. No response appears for the dropped operation.
- **Operand isolation:**
  - Stimulus: change `req0_a` to 0 in the cycle after the handshake of a=0000FFFF, b=8, aluc=01.
  - Response: `rsp_data`=000000FF.
